// File: rtl/reflet_int_ctrl.sv
// ---------------------------------------------------------------------------
// reflet_int_ctrl
//   Four-source interrupt controller for the Reflet CPU. It has four
//   memory-mapped 4-bit registers starting at base_addr:
//     +0 PENDING  read, write-1-to-clear
//     +1 MASK     read/write
//     +2 MODE     read/write (1 = rising-edge capture, 0 = level capture)
//     +3 OVERRUN  read, write-1-to-clear
//   Raw sources pass through a two-flop synchroniser. A third flop holds the
//   previous synchronised value, which edge detection compares against.
//
// Ports
//   clk       in   single clock; all state changes on its rising edge
//   reset     in   asynchronous, active-high reset
//   enable    in   bus access enable; gates register reads and writes only
//   addr      in   CPU address            [wordsize-1:0]
//   data_in   in   CPU write data         [wordsize-1:0], only [3:0] used
//   write_en  in   CPU write strobe
//   data_out  out  registered read data   [wordsize-1:0]
//   src_in    in   raw interrupt sources  [3:0], asynchronous to clk
//   ext_int   out  registered PENDING & MASK, to the CPU ext_int input
//
// Bus handshake: there is no valid/ready pair. An access occurs on a rising
// edge where enable=1 and addr hits a register. A write also needs
// write_en=1. Read data shows up on data_out one cycle after the access.
// While enable=0, data_out holds its last value.
// ---------------------------------------------------------------------------
module reflet_int_ctrl #(
    parameter int                  wordsize  = 8,
    parameter logic [wordsize-1:0] base_addr = 8'hF0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    input  logic [3:0]          src_in,
    output logic [3:0]          ext_int
);

    logic [3:0]          r_sync1;
    logic [3:0]          r_sync2;
    logic [3:0]          r_prev;
    logic [3:0]          r_pending;
    logic [3:0]          r_mask;
    logic [3:0]          r_mode;
    logic [3:0]          r_overrun;
    logic [3:0]          r_ext_int;
    logic [wordsize-1:0] r_data_out;

    logic [wordsize-1:0] w_off;
    logic                w_hit;
    logic                w_wr;
    logic [3:0]          w_clr_pend;
    logic [3:0]          w_clr_ovr;
    logic [3:0]          w_edge;
    logic [3:0]          w_level;
    logic [3:0]          w_set;
    logic [3:0]          w_ovr_set;
    logic [3:0]          w_rd;

    // Wrapping subtraction. An address hits when it lies in base_addr..+3.
    assign w_off = addr - base_addr;
    assign w_hit = (w_off[wordsize-1:2] == '0);
    assign w_wr  = enable & write_en & w_hit;

    assign w_clr_pend = (w_wr && (w_off[1:0] == 2'd0)) ? data_in[3:0] : 4'h0;
    assign w_clr_ovr  = (w_wr && (w_off[1:0] == 2'd3)) ? data_in[3:0] : 4'h0;

    assign w_edge  = r_sync2 & ~r_prev & r_mode;
    assign w_level = r_sync2 & ~r_mode;
    assign w_set   = w_edge | w_level;

    // An edge that lands on a pending bit is an overrun, unless that same
    // cycle clears the bit. In that case the new event simply re-arms it.
    assign w_ovr_set = w_edge & r_pending & ~w_clr_pend;

    always_comb begin
        w_rd = 4'h0;
        case (w_off[1:0])
            2'd0:    w_rd = r_pending;
            2'd1:    w_rd = r_mask;
            2'd2:    w_rd = r_mode;
            default: w_rd = r_overrun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 4'h0;
            r_sync2    <= 4'h0;
            r_prev     <= 4'h0;
            r_pending  <= 4'h0;
            r_mask     <= 4'h0;
            r_mode     <= 4'h0;
            r_overrun  <= 4'h0;
            r_ext_int  <= 4'h0;
            r_data_out <= '0;
        end else begin
            r_sync1 <= src_in;
            r_sync2 <= r_sync1;
            // prev follows sync2 every cycle, in both modes. A MODE write
            // therefore always finds prev == the last sync2, so switching a
            // high source to edge mode cannot produce a false edge.
            r_prev  <= r_sync2;

            // A new set takes priority over a W1C of the same bit.
            r_pending <= (r_pending & ~w_clr_pend) | w_set;
            r_overrun <= (r_overrun & ~w_clr_ovr) | w_ovr_set;

            if (w_wr && (w_off[1:0] == 2'd1)) begin
                r_mask <= data_in[3:0];
            end
            if (w_wr && (w_off[1:0] == 2'd2)) begin
                r_mode <= data_in[3:0];
            end

            r_ext_int <= r_pending & r_mask;

            if (enable) begin
                r_data_out <= w_hit ? {{(wordsize-4){1'b0}}, w_rd} : '0;
            end
        end
    end

    assign data_out = r_data_out;
    assign ext_int  = r_ext_int;

endmodule

// File: doc/reflet_int_ctrl.md
REFLET_INT_CTRL -- requirements
Module: reflet_int_ctrl

Interface
REQ-001 SHALL have parameter wordsize, default 8: width of the CPU data and address bus.
REQ-002 SHALL have parameter base_addr, default 8'hF0: first of four consecutive register addresses.
REQ-003 SHALL have port clk  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1: bus access enable; low blocks register reads and writes only.
REQ-006 SHALL have port addr  input  wordsize: CPU address.
REQ-007 SHALL have port data_in  input  wordsize: CPU write data (CPU data_out).
REQ-008 SHALL have port write_en  input  1: CPU write strobe.
REQ-009 SHALL have port data_out  output  wordsize: registered read data to CPU.
REQ-010 SHALL have port src_in  input  4: raw interrupt sources, asynchronous to clk.
REQ-011 SHALL have port ext_int  output  4: interrupt requests to the CPU ext_int input.

Function
REQ-012 SHALL synchronise each src_in bit through two flops, then keep a third flop (previous value) for edge detection.
REQ-013 SHALL hold 4-bit registers: offset 0 PENDING (read, write-1-to-clear), offset 1 MASK (read/write), offset 2 MODE (read/write; bit=1 rising-edge, bit=0 level), offset 3 OVERRUN (read, write-1-to-clear).
REQ-014 SHALL decode a register hit when addr equals base_addr+offset (offset 0..3); all other addresses are ignored.
REQ-015 SHALL perform a write when write_en=1, enable=1 and addr hits; only data_in[3:0] is used.
REQ-016 SHALL register data_out one cycle after addr is presented when enable=1: hit gives {zeros, reg[3:0]}, miss gives 0; enable=0 holds the previous data_out.
REQ-017 Edge mode: PENDING[i] SHALL set on the cycle after sync2 goes 0->1 (sync2=1, prev=0).
REQ-018 Level mode: PENDING[i] SHALL be set every cycle sync2[i]=1; a W1C while the level is high has no effect.
REQ-019 Capture SHALL continue regardless of enable; no event is lost while the CPU is disabled.
REQ-020 Set SHALL win over a same-cycle W1C of the same PENDING bit.
REQ-021 OVERRUN[i] SHALL set when an edge-mode event arrives while PENDING[i] is already 1 and not being cleared that cycle; it is never set in level mode.
REQ-022 ext_int SHALL be registered: ext_int <= PENDING & MASK each cycle. A mask change appears on ext_int one cycle after the write.
REQ-023 Latency: a src_in rising edge captured on clk edge N SHALL give ext_int=1 after edge N+3 (sync1 N, sync2 N+1, PENDING N+2, ext_int N+3), when unmasked.
REQ-024 ext_int[i] SHALL stay high until PENDING[i] is cleared or MASK[i] is cleared; it is never auto-cleared.
REQ-025 A write to MODE SHALL reload the prev flop from sync2 on the same cycle, so no spurious edge is seen.
REQ-026 Unused data_in bits SHALL be ignored. Writes to offset 0 or 3 with a bit at 0 SHALL leave that bit unchanged.

Reset
REQ-027 While reset=1, all synchroniser flops, PENDING, MASK, MODE, OVERRUN, ext_int and data_out SHALL be 0, asynchronously.
REQ-028 After reset, all sources SHALL be level-mode and masked. A source held high through reset deassertion SHALL set PENDING in level mode only.
REQ-029 reset mid-operation SHALL discard pending and overrun state immediately; no ext_int glitch after release.

Verification
REQ-030 Write MASK=4'h1 and MODE=4'h1; pulse src_in[0] high for 5 cycles -> ext_int=4'b0001 exactly 3 edges after capture; PENDING reads 4'h1; write 4'h1 to offset 0 -> ext_int=0 next cycle.
REQ-031 Edge mode, PENDING[0]=1; second src_in[0] pulse -> OVERRUN reads 4'h1; write 4'h1 to offset 3 -> reads 4'h0.
REQ-032 Level mode, MASK=4'hF, src_in[2] held high; W1C 4'h4 -> PENDING stays 4'h4; drop src_in[2], then W1C -> PENDING 4'h0, ext_int 4'h0.
REQ-033 Hold enable=0; pulse src_in[0] (edge mode, masked in) -> ext_int asserts; a write to MASK=0 is ignored; raise enable, read offset 0 -> data_out=8'h01 one cycle later.
REQ-034 Same-cycle W1C of PENDING[1] and a new src edge1 reaching PENDING -> PENDING[1] remains 1, OVERRUN[1] remains 0; read of addr base_addr+4 -> data_out=0.
REQ-035 Assert reset asynchronously mid-cycle with ext_int=4'hF -> all outputs 0 immediately, MASK reads 0 after release.
